peak_tracker: RTL

PEAK_TRACKER -- requirements
Module: peak_tracker

---
 rtl/peak_tracker.sv | 73 +++++++
 1 files changed

// File: rtl/peak_tracker.sv
// peak_tracker: per-frame running maximum with first-occurrence index and tie count.
module peak_tracker #(
  parameter int FRAME_LEN = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       x,
  output logic [3:0]       y_out,
  input  logic             lg_in,
  input  logic             eq_in,
  input  logic             rg_in,
  output logic [3:0]       max_out,
  output logic [IDX_W-1:0] max_idx,
  output logic [3:0]       tie_cnt,
  output logic             done,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, FIRST, RUN, DONE} state_t;
  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(FRAME_LEN - 1);
  state_t state;
  logic [IDX_W:0] cnt;
  logic [2:0] flags;
  assign flags = {lg_in, eq_in, rg_in};
  assign in_ready = (state == FIRST) || (state == RUN);
  assign done = (state == DONE);
  assign y_out = max_out;
  // cnt is one bit wider than the index so it can reach FRAME_LEN == 2**IDX_W
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      max_out <= '0;
      max_idx <= '0;
      tie_cnt <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= FIRST;
          max_out <= '0;
          max_idx <= '0;
          tie_cnt <= '0;
          cnt <= '0;
          err <= 1'b0;
        end
        FIRST: if (in_valid) begin
          max_out <= x;
          max_idx <= '0;
          tie_cnt <= '0;
          cnt <= (IDX_W+1)'(1);
          state <= (FRAME_LEN == 1) ? DONE : RUN;
        end
        RUN: if (in_valid) begin
          cnt <= cnt + 1'b1;
          if (flags == 3'b100) begin
            max_out <= x;
            max_idx <= cnt[IDX_W-1:0];
            tie_cnt <= '0;
          end else if (flags == 3'b010) begin
            tie_cnt <= tie_cnt + {3'b000, tie_cnt != 4'hf};
          end else if (flags != 3'b001) begin
            err <= 1'b1;
          end
          if (cnt == LAST) state <= DONE;
        end
      endcase
    end
  end
endmodule
